// File: rtl/led_pattern_player_pkg.sv
// Shared types and constants for the LED pattern player.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pattern_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Flops between the asynchronous blinker output and the edge detector.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/led_pattern_player_if.sv
// Control/status bundle between a sequencer and the LED pattern player.
// Latency: n/a (wires only).
// Backpressure: none; start is honoured only while the player is idle (busy_out1 low).
// Ports: tick/start/pattern/repeat/abort flow master->slave, led/busy/done flow slave->master.
interface led_pattern_player_if #(
    parameter int PAT_W = 8,
    parameter int REP_W = 4
);
    logic             tick_in1;
    logic             start_in1;
    logic [PAT_W-1:0] pattern_in1;
    logic [REP_W-1:0] repeat_in1;
    logic             abort_in1;
    logic             led_out1;
    logic             busy_out1;
    logic             done_out1;

    modport master (
        output tick_in1,
        output start_in1,
        output pattern_in1,
        output repeat_in1,
        output abort_in1,
        input  led_out1,
        input  busy_out1,
        input  done_out1
    );

    modport slave (
        input  tick_in1,
        input  start_in1,
        input  pattern_in1,
        input  repeat_in1,
        input  abort_in1,
        output led_out1,
        output busy_out1,
        output done_out1
    );
endinterface

// File: rtl/led_pattern_player_tick_edge_sync.sv
// Synchronises the blinker level and emits a one-cycle step on every level change.
// Latency: a change seen at edge k gives step high during the cycle after edge k+1.
// Backpressure: none; every level change yields exactly one step pulse.
// Ports: clk_in1/rst_n_in1 clock and async active-low reset, tick_in1 raw level, step_out1 pulse.
module tick_edge_sync
    import led_pattern_pkg::*;
(
    input  logic clk_in1,
    input  logic rst_n_in1,
    input  logic tick_in1,
    output logic step_out1
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_in1 or negedge rst_n_in1) begin
        if (!rst_n_in1) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in1};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // Either direction of change counts as one step.
    assign step_out1 = sync_q[SYNC_STAGES-1] ^ dly_q;

endmodule

// File: rtl/led_pattern_player.sv
// Plays a latched bit pattern (MSB first) onto an LED, one bit per blinker toggle, repeated N+1 times.
// Latency: start -> busy/led after 1 edge; tick change -> led update after 2 edges.
// Backpressure: start ignored while busy; abort cancels immediately without a done pulse.
// Ports: clk_in1, rst_n_in1 (async active-low), bus = slave side of led_pattern_player_if.
module led_pattern_player
    import led_pattern_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int REP_W = 4
) (
    input  logic                 clk_in1,
    input  logic                 rst_n_in1,
    led_pattern_player_if.slave  bus
);

    localparam int                IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PAT_W - 1);

    state_t           state_q,   state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             led_q,     led_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             step;
    logic [PAT_W-1:0] next_bits;

    tick_edge_sync u_sync (
        .clk_in1   (clk_in1),
        .rst_n_in1 (rst_n_in1),
        .tick_in1  (bus.tick_in1),
        .step_out1 (step)
    );

    // Bit to show after the current one sits at the MSB once the already-played
    // bits are shifted out; only consulted while bit_idx_q < LAST_IDX.
    assign next_bits = pattern_q << (bit_idx_q + IDX_W'(1));

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        bit_idx_d = bit_idx_q;
        rep_cnt_d = rep_cnt_q;
        led_d     = led_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Steps arriving while idle are simply dropped.
                if (bus.start_in1) begin
                    pattern_d = bus.pattern_in1;
                    rep_cnt_d = bus.repeat_in1;
                    bit_idx_d = '0;
                    led_d     = bus.pattern_in1[PAT_W-1];
                    busy_d    = 1'b1;
                    state_d   = PLAY;
                end
            end
            PLAY: begin
                if (bus.abort_in1) begin
                    led_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (step) begin
                    if (bit_idx_q != LAST_IDX) begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        led_d     = next_bits[PAT_W-1];
                    end else if (rep_cnt_q != '0) begin
                        rep_cnt_d = rep_cnt_q - REP_W'(1);
                        bit_idx_d = '0;
                        led_d     = pattern_q[PAT_W-1];
                    end else begin
                        led_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in1 or negedge rst_n_in1) begin
        if (!rst_n_in1) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            bit_idx_q <= '0;
            rep_cnt_q <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            bit_idx_q <= bit_idx_d;
            rep_cnt_q <= rep_cnt_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.led_out1  = led_q;
    assign bus.busy_out1 = busy_q;
    assign bus.done_out1 = done_q;

endmodule
